// File: rtl/bp_me_pkg.sv
// Memory-side message types, the test-memory FSM state encoding and the
// byte-mask helper shared by the CCE test memory and its bench.
package bp_me_pkg;

  localparam int paddr_width_p         = 40;
  localparam int cce_block_width_p     = 512;
  localparam int block_bytes_lp        = cce_block_width_p / 8;
  localparam int block_offset_width_lp = $clog2(block_bytes_lp);
  localparam int mem_payload_width_lp  = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_wb    = 4'd4
  } bp_cce_mem_cmd_type_e;

  // size encodes 2^size bytes; 6 and above mean the whole 64-byte block.
  typedef struct packed {
    logic [mem_payload_width_lp-1:0] payload;
    logic [2:0]                      size;
    logic [paddr_width_p-1:0]        addr;
    bp_cce_mem_cmd_type_e            msg_type;
    logic [cce_block_width_p-1:0]    data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2
  } bp_cce_test_mem_state_e;

  function automatic logic [block_bytes_lp-1:0] size_byte_mask(input logic [2:0] size);
    logic [block_bytes_lp-1:0] m;
    m = '0;
    for (int i = 0; i < block_bytes_lp; i++) begin
      if (i < (1 << size)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bp_cce_test_mem_latency_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module bp_cce_test_mem_latency_counter #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic [width_p-1:0] count_o,
  output logic               zero_o
);

  logic [width_p-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/bp_cce_test_mem.sv
// Single-outstanding memory model behind the CCE memory-command port: applies
// writes at accept, snapshots read data at accept, responds after a fixed latency.
module bp_cce_test_mem
  import bp_me_pkg::*;
#(
  parameter int mem_els_p     = 256,
  parameter int mem_latency_p = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,
  output bp_cce_test_mem_state_e          state_o
);

  // Handshake: a command transfers on a rising edge where mem_cmd_v_i and
  // mem_cmd_ready_o are both high; a response transfers on a rising edge where
  // mem_resp_v_o and mem_resp_yumi_i are both high. Only one transaction is in
  // flight, so ready stays low from accept until the edge after yumi.

  localparam int idx_width_lp = $clog2(mem_els_p);
  localparam int cnt_width_lp = $clog2(mem_latency_p) + 1;

  bp_cce_test_mem_state_e state_d, state_q;
  bp_cce_mem_msg_s        cmd, resp_d, resp_q;

  logic [cce_block_width_p-1:0] mem_q [mem_els_p];

  logic [idx_width_lp-1:0]          mem_idx;
  logic [block_offset_width_lp-1:0] size_m1, byte_off;
  logic [block_bytes_lp-1:0]        size_bytes, byte_en;
  logic [cce_block_width_p-1:0]     size_bits, bit_en, old_blk, mem_wdata, rdata;
  logic                             mem_we, accept;
  logic                             cnt_load, cnt_dec, cnt_zero;
  logic [cnt_width_lp-1:0]          cnt;

  assign mem_cmd_ready_o = (state_q == S_READY) && !reset_i;
  assign accept          = mem_cmd_ready_o && mem_cmd_v_i;
  assign mem_resp_v_o    = (state_q == S_RESP);
  assign mem_resp_o      = resp_q;
  assign state_o         = state_q;

  bp_cce_test_mem_latency_counter #(
    .width_p(cnt_width_lp)
  ) latency_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_width_lp'(mem_latency_p - 1)),
    .dec_i     (cnt_dec),
    .count_o   (cnt),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_READY: begin
        if (accept) begin
          cnt_load = 1'b1;
          state_d  = (mem_latency_p == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_dec = 1'b1;
        // Leave on the edge that takes the count to zero.
        if (cnt_zero || (cnt == cnt_width_lp'(1))) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_yumi_i) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  always_comb begin
    cmd     = bp_cce_mem_msg_s'(mem_cmd_i);
    mem_idx = cmd.addr[block_offset_width_lp +: idx_width_lp];
    for (int k = 0; k < block_offset_width_lp; k++) begin
      size_m1[k] = (k < int'(cmd.size));
    end
    // Uncached accesses are aligned down to their own size inside the block.
    byte_off   = cmd.addr[block_offset_width_lp-1:0] & ~size_m1;
    size_bytes = size_byte_mask(cmd.size);
    byte_en    = size_bytes << byte_off;
    for (int i = 0; i < block_bytes_lp; i++) begin
      size_bits[8*i +: 8] = {8{size_bytes[i]}};
      bit_en[8*i +: 8]    = {8{byte_en[i]}};
    end
    old_blk   = mem_q[mem_idx];
    mem_we    = 1'b0;
    mem_wdata = old_blk;
    rdata     = '0;
    case (cmd.msg_type)
      e_cce_mem_wr, e_cce_mem_wb: begin
        mem_we    = accept;
        mem_wdata = cmd.data;
      end
      e_cce_mem_uc_wr: begin
        mem_we    = accept;
        mem_wdata = (old_blk & ~bit_en) | ((cmd.data << {byte_off, 3'b000}) & bit_en);
      end
      e_cce_mem_rd:    rdata = old_blk;
      e_cce_mem_uc_rd: rdata = (old_blk >> {byte_off, 3'b000}) & size_bits;
      default: ;
    endcase
    resp_d = resp_q;
    if (accept) begin
      resp_d      = cmd;
      resp_d.data = rdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_READY;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < mem_els_p; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_bp_cce_test_mem.sv
// Scenario bench for bp_cce_test_mem: expected responses are queued at issue
// and compared when the response handshake happens.
module tb_bp_cce_test_mem;
  import bp_me_pkg::*;

  localparam int MEM_ELS = 256;
  localparam int LAT     = 4;
  localparam int W       = cce_mem_msg_width_lp;
  localparam int BW      = cce_block_width_p;

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [W-1:0]           mem_cmd_i;
  logic                   mem_cmd_v_i;
  logic                   mem_cmd_ready_o;
  logic [W-1:0]           mem_resp_o;
  logic                   mem_resp_v_o;
  logic                   mem_resp_yumi_i;
  bp_cce_test_mem_state_e state_o;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_cce_test_mem #(
    .mem_els_p    (MEM_ELS),
    .mem_latency_p(LAT)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .mem_cmd_i      (mem_cmd_i),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_resp_o     (mem_resp_o),
    .mem_resp_v_o   (mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i),
    .state_o        (state_o)
  );

  function automatic logic [W-1:0] mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] addr,
                                      input logic [2:0] size, input logic [BW-1:0] data);
    bp_cce_mem_msg_s m;
    m.msg_type = t;
    m.addr     = addr;
    m.size     = size;
    m.payload  = 16'($urandom);
    m.data     = data;
    return m;
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW/32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] cmd, input logic [BW-1:0] exp_data, output int acc_cyc);
    bp_cce_mem_msg_s r;
    int n = 0;
    mem_cmd_i   = cmd;
    mem_cmd_v_i = 1'b1;
    while (!mem_cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept: ready=%b required 1 within 50 cycles", mem_cmd_ready_o);
    end
    acc_cyc = cyc;
    r       = cmd;
    r.data  = exp_data;
    exp_q.push_back(r);
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
  endtask

  task automatic collect(input int acc_cyc, input string name, input int hold);
    logic [W-1:0] exp_v;
    logic [W-1:0] first;
    int n = 0;
    while (!mem_resp_v_o && n < 50) begin
      checks++;
      if (mem_cmd_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_ready: ready=%b required 0", name, mem_cmd_ready_o);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_resp_v_o !== 1'b1 || (cyc - acc_cyc) != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (v=%b) required %0d", name, cyc - acc_cyc, mem_resp_v_o, LAT);
    end
    first = mem_resp_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (mem_resp_o !== first || mem_resp_v_o !== 1'b1 || mem_cmd_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: v=%b ready=%b stable=%b required v=1 ready=0 stable=1",
                 name, h, mem_resp_v_o, mem_cmd_ready_o, mem_resp_o === first);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: response with empty expected queue", name);
    end else begin
      exp_v = exp_q.pop_front();
      if (mem_resp_o !== exp_v) begin
        errors++;
        $display("FAIL %s resp: got %h required %h", name, mem_resp_o, exp_v);
      end
    end
    mem_resp_yumi_i = 1'b1;
    checks++;
    if (mem_cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s yumi_ready: ready=%b required 0", name, mem_cmd_ready_o);
    end
    @(negedge clk);
    mem_resp_yumi_i = 1'b0;
    checks++;
    if (mem_resp_v_o !== 1'b0 || mem_cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s release: v=%b ready=%b required v=0 ready=1", name, mem_resp_v_o, mem_cmd_ready_o);
    end
  endtask

  task automatic txn(input logic [W-1:0] cmd, input logic [BW-1:0] exp_data, input string name);
    int acc;
    issue(cmd, exp_data, acc);
    collect(acc, name, 0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_cmd_ready_o !== 1'b0 || mem_resp_v_o !== 1'b0 || mem_resp_o !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b v=%b resp_zero=%b required 0 0 1",
               mem_cmd_ready_o, mem_resp_v_o, mem_resp_o === '0);
    end
    reset_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_cmd_ready_o !== 1'b1 || state_o !== S_READY) begin
      errors++;
      $display("FAIL idle_ready: ready=%b state=%0d required 1 and S_READY", mem_cmd_ready_o, state_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (mem_resp_v_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_resp: v=%b required 0", mem_resp_v_o);
      end
    end
  endtask

  task automatic test_wr_rd;
    txn(mk(e_cce_mem_wr, 40'h80, 3'd6, {64{8'hA5}}), '0, "wr_80");
    txn(mk(e_cce_mem_rd, 40'h80, 3'd6, rand_blk()), {64{8'hA5}}, "rd_80");
  endtask

  task automatic test_uncached;
    logic [BW-1:0] blk, d, e;
    blk = {64{8'hA5}};
    blk[64 +: 64] = 64'h1122334455667788;
    d = rand_blk();
    d[63:0] = 64'h1122334455667788;
    txn(mk(e_cce_mem_uc_wr, 40'h88, 3'd3, d), '0, "ucwr_88");
    e = '0; e[63:0] = 64'h1122334455667788;
    txn(mk(e_cce_mem_uc_rd, 40'h88, 3'd3, rand_blk()), e, "ucrd8_88");
    e = '0; e[7:0] = 8'h66;
    txn(mk(e_cce_mem_uc_rd, 40'h8A, 3'd0, rand_blk()), e, "ucrd1_8a");
    // Misaligned 4-byte write lands aligned down at 0x90.
    d = rand_blk();
    d[31:0] = 32'hDEADBEEF;
    blk[16*8 +: 32] = 32'hDEADBEEF;
    txn(mk(e_cce_mem_uc_wr, 40'h93, 3'd2, d), '0, "ucwr4_93");
    e = '0; e[15:0] = 16'hBEEF;
    txn(mk(e_cce_mem_uc_rd, 40'h91, 3'd1, rand_blk()), e, "ucrd2_91");
    txn(mk(e_cce_mem_uc_rd, 40'hA7, 3'd6, rand_blk()), blk, "ucrd64_a7");
    txn(mk(e_cce_mem_rd, 40'h80, 3'd6, rand_blk()), blk, "rd_80_merged");
  endtask

  task automatic test_alias;
    logic [BW-1:0] d;
    d = rand_blk();
    txn(mk(e_cce_mem_wr, 40'(MEM_ELS * 64), 3'd6, d), '0, "wr_alias");
    txn(mk(e_cce_mem_rd, 40'h0, 3'd6, rand_blk()), d, "rd_alias_0");
    txn(mk(e_cce_mem_rd, 40'hAB_0000_4000, 3'd6, rand_blk()), d, "rd_alias_hi");
    txn(mk(bp_cce_mem_cmd_type_e'(4'hF), 40'h0, 3'd6, ~d), '0, "unknown_type");
    txn(mk(e_cce_mem_rd, 40'h0, 3'd6, rand_blk()), d, "rd_after_unknown");
  endtask

  task automatic test_random;
    logic [BW-1:0] d;
    logic [39:0]   a;
    for (int i = 0; i < 4; i++) begin
      d = rand_blk();
      a = 40'($urandom_range(16, 200) * 64);
      txn(mk(e_cce_mem_wb, a, 3'd6, d), '0, "rand_wb");
      txn(mk(e_cce_mem_rd, a | 40'($urandom_range(0, 63)), 3'd6, rand_blk()), d, "rand_rd");
    end
  endtask

  task automatic test_back_to_back;
    logic [BW-1:0]   d;
    logic [W-1:0]    rd_cmd;
    bp_cce_mem_msg_s r;
    int acc, acc2;
    d = rand_blk();
    issue(mk(e_cce_mem_wr, 40'h300, 3'd6, d), '0, acc);
    rd_cmd      = mk(e_cce_mem_rd, 40'h300, 3'd6, rand_blk());
    mem_cmd_i   = rd_cmd;
    mem_cmd_v_i = 1'b1;
    collect(acc, "bp_wr", 10);
    // Negedge after the yumi edge: ready is high, so the held command goes in now.
    acc2   = cyc;
    r      = rd_cmd;
    r.data = d;
    exp_q.push_back(r);
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
    collect(acc2, "bp_rd", 0);
  endtask

  task automatic test_reset_mid;
    logic [BW-1:0] d;
    d = rand_blk();
    txn(mk(e_cce_mem_wr, 40'h200, 3'd6, d), '0, "pre_reset_wr");
    mem_cmd_i   = mk(e_cce_mem_rd, 40'h200, 3'd6, '0);
    mem_cmd_v_i = 1'b1;
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    checks++;
    if (mem_cmd_ready_o !== 1'b0 || mem_resp_v_o !== 1'b0 || mem_resp_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b v=%b resp_zero=%b required 0 0 1",
               mem_cmd_ready_o, mem_resp_v_o, mem_resp_o === '0);
    end
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (mem_resp_v_o !== 1'b0 || mem_cmd_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle: v=%b ready=%b required 0 1", mem_resp_v_o, mem_cmd_ready_o);
      end
    end
    txn(mk(e_cce_mem_rd, 40'h200, 3'd6, rand_blk()), '0, "rd_after_reset");
    txn(mk(e_cce_mem_rd, 40'h300, 3'd6, rand_blk()), '0, "rd_other_after_reset");
  endtask

  initial begin
    reset_i         = 1'b1;
    mem_cmd_i       = '0;
    mem_cmd_v_i     = 1'b0;
    mem_resp_yumi_i = 1'b0;
    test_reset;
    test_wr_rd;
    test_uncached;
    test_alias;
    test_random;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected responses never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bp_cce_test_mem.md
# bp_cce_test_mem

Non-synthesizable single-outstanding memory model for the standalone CCE testbench. It sits directly downstream of the CCE's memory-command port: it consumes mem_cmd messages, applies writes to an internal block array, and returns mem_resp messages after a fixed programmable latency. This closes the CCE-MEM loop so coherence traffic can be exercised without a real memory system.

## Interface
Parameters:
- bp_params_p, BP_CFG_FLOWVAR: processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p.
- mem_els_p, 256: number of cache blocks held; power of two, at least 2.
- mem_latency_p, 4: cycles from command accept to response valid; at least 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  reset; asynchronous, active-high.
- mem_cmd_i  in  cce_mem_msg_width_lp  command message (msg_type, addr, size, payload, data).
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  ready to accept a command.
- mem_resp_o  out  cce_mem_msg_width_lp  response message.
- mem_resp_v_o  out  1  response valid.
- mem_resp_yumi_i  in  1  consumer takes the response this cycle; asserted only while mem_resp_v_o is high.

## Operation
- FSM states: S_READY, S_WAIT, S_RESP.
- S_READY: mem_cmd_ready_o=1. On mem_cmd_v_i, latch the header, load the counter with mem_latency_p-1, and go to S_WAIT, or directly to S_RESP when mem_latency_p=1.
- S_WAIT: decrement the counter each cycle; go to S_RESP when it reaches 0.
- S_RESP: mem_resp_v_o=1. On mem_resp_yumi_i, go to S_READY.
- Block index = addr[log2(block bytes) +: log2(mem_els_p)]. Higher address bits are ignored, so accesses alias modulo mem_els_p blocks.
- e_cce_mem_wr / e_cce_mem_wb: overwrite the full block with data on the accept edge.
- e_cce_mem_uc_wr: write 2^size bytes (size from 1 to 64 bytes) taken from the low bytes of data. Write them at the byte offset addr[log2(block bytes)-1:0], aligned down to the size. Other bytes are unchanged.
- e_cce_mem_rd: response data is the full block.
- e_cce_mem_uc_rd: response data is the addressed 2^size bytes, right-aligned and zero-extended.
- Read data is sampled at the accept edge, so a read sees all earlier writes.
- Response header echoes msg_type, addr, size and payload of the command. Response data is zero for writes.
- Unknown msg_type: memory is unchanged, and the response is returned with zero data.

## Timing
- Accepted at edge t, meaning mem_cmd_v_i&&mem_cmd_ready_o is high in the cycle before edge t. Then mem_resp_v_o is high from t+mem_latency_p-1 (cycle index) until yumi, giving exactly mem_latency_p cycles of latency.
- mem_cmd_ready_o is low from the accept edge until the edge after yumi. There is no back-to-back accept with a pending response: one transaction at a time.
- Yumi and a new command valid in the same cycle: the new command is not accepted. It is accepted in the next S_READY cycle.
- mem_resp_o is stable while mem_resp_v_o is high.
- Reset, including mid-transaction: state goes to S_READY, counter to 0, mem_resp_v_o to 0, mem_resp_o to 0, and mem_cmd_ready_o is 0 while reset_i is high. The memory array is cleared to zero. A pending response is dropped. An accepted write is retained only if its accept edge preceded reset assertion.

## Structure
- FSM state enum and the per-size byte-mask function belong in bp_me_pkg.
- Message struct and msg_type enum come from the existing bp_me interface macros; do not redeclare them.
- One natural sub-module: bp_cce_test_mem_latency_counter, a loadable down-counter with a zero flag.
- Array is a plain reg array inferred in the top module.

## Test plan
- Reset then idle: mem_cmd_ready_o=1, mem_resp_v_o=0, and no response appears.
- Write then read, mem_latency_p=4:
  - wr to addr 0x80 with data 0xA5 repeated, then rd to 0x80.
  - Required: each response valid exactly 4 cycles after its accept; rd data is all 0xA5; headers echo the commands.
- Uncached write then read:
  - uc_wr of size 8 bytes, addr 0x88, data 0x1122334455667788.
  - Then uc_rd of size 8 at 0x88 returns 0x1122334455667788.
  - uc_rd of size 1 at 0x8A returns 0x66.
  - The full-block rd of 0x80 shows the other bytes unchanged.
- Aliasing: wr to block index mem_els_p (addr mem_els_p*block bytes), then rd of addr 0 returns the same data.
- Backpressure: hold yumi low for 10 cycles after response valid.
  - Required: response stays stable, ready stays 0, and a concurrently valid command is accepted only the cycle after yumi.
- Reset mid-transaction: assert reset in S_WAIT.
  - Required: no response is produced, ready returns after deassertion, and a subsequent rd of the written block returns zero.
